dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder (target side) for the core's data port. Accepts
//   word load/store requests through a req/ready handshake. Services them from
//   an internal word RAM after a programmable number of wait states. Flags
//   misaligned and out-of-range accesses. Sits between the core's memory
//   stage and the SoC top in place of a zero-latency data memory.
// PARAMETERS
//   DEPTH_WORDS  64            number of 32-bit words in RAM (power of two, >=4)
//   WAIT_STATES  2             extra cycles between acceptance and response (0..15)
//   BASE_ADDR    32'h0000_0000 byte address of word 0 (word aligned)
// PORTS
//   clk        in   1   clock, all state on rising edge
//   reset      in   1   asynchronous, ACTIVE-LOW reset (0 = reset asserted)
//   MemReq     in   1   initiator request valid
//   MemWrite   in   1   1 = store, 0 = load; qualified by MemReq
//   Addr       in   32  byte address (ALUResult of the core)
//   WriteData  in   32  store data
//   ReadData   out  32  load data; valid only while MemReady=1 and MemErr=0
//   MemReady   out  1   one-cycle response strobe, completes the request
//   MemErr     out  1   response is an error; asserted only with MemReady
//   Busy       out  1   1 while a request is in flight (state != IDLE)
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE, ReadData=0, MemReady=0, MemErr=0,
//     Busy=0, wait counter=0. RAM contents are NOT cleared.
//   FSM states: IDLE, WAIT, RESP.
//   IDLE: if MemReq=1, accept. Latch MemWrite/Addr/WriteData into request
//     registers. Go to WAIT if WAIT_STATES>0 (counter=WAIT_STATES-1).
//     Otherwise go to RESP.
//   WAIT: decrement counter each cycle; go to RESP when counter==0.
//   RESP: MemReady=1 for exactly this cycle, then return to IDLE.
//     MemReq is ignored while in RESP.
//   Latency: acceptance edge to MemReady high = WAIT_STATES+1 cycles.
//     Minimum request spacing = WAIT_STATES+2 cycles.
//   Handshake: initiator holds MemReq and payload until it samples
//     MemReady=1. The responder uses only latched values, so payload changes
//     after acceptance have no effect.
//   MemReq still high in the IDLE cycle after RESP: this is a NEW request and
//     is accepted. The initiator must drop MemReq in the MemReady cycle if it
//     has no new request.
//   Decode (on latched Addr): off = Addr - BASE_ADDR (32-bit wrap arithmetic).
//     index = off[31:2].
//     error if Addr[1:0]!=0, or if Addr < BASE_ADDR, or if index >= DEPTH_WORDS.
//   Store, no error: RAM[index] <= WriteData on the edge entering RESP.
//     ReadData=0 in RESP.
//   Load, no error: ReadData = RAM[index], registered on the edge entering
//     RESP and held until the next response. A load returns data written by
//     any earlier completed store.
//   Error: MemErr=1 with MemReady, ReadData=0, RAM unchanged.
//   MemErr and ReadData are driven as in RESP only. Outside RESP, MemErr=0 and
//     ReadData holds its last value.
//   Reset mid-operation: in-flight request aborted, no MemReady, and a pending
//     store is NOT committed.
//   X on MemReq while in IDLE is illegal (assertion in bench).
// TESTING
//   1 WAIT_STATES=2: store 0xDEADBEEF @0x10, then load @0x10 -> MemReady 3
//     cycles after each accept; load ReadData=0xDEADBEEF, MemErr=0.
//   2 WAIT_STATES=0: back-to-back loads @0x0, @0x4 with MemReq held high ->
//     MemReady every 2nd cycle; Busy toggles 1,0.
//   3 Load @0x12 (misaligned) and @DEPTH_WORDS*4 (out of range) -> MemReady=1,
//     MemErr=1, ReadData=0; a follow-up load shows RAM unchanged.
//   4 BASE_ADDR=0x1000: store @0x0FFC -> error; store 0x55 @0x1000, then load
//     @0x1000 -> 0x55.
//   5 Store 0x1234 @0x8, drive reset=0 mid-WAIT -> no MemReady, all outputs 0;
//     after release, load @0x8 returns the old value, not 0x1234.
//   6 Change Addr/WriteData during WAIT after acceptance -> response reflects
//     the originally latched values.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory target for the core data port.
// Word RAM behind a req/ready handshake with alignment and range errors.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr,
  output logic        Busy
);

  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t        state;
  logic [3:0]    cnt;
  req_t          req_q;
  req_t          src;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   off;
  logic [IW-1:0] idx;
  logic          dec_err;
  logic          go_resp;
  logic          commit;
  logic [31:0]   rdata;

  // With zero wait states the response is built from the accepted payload.
  always_comb begin
    src = req_q;
    if (state == S_IDLE) begin
      src = {MemWrite, Addr, WriteData};
    end
  end

  assign off = src.addr - BASE_ADDR;
  assign idx = off[IW+1:2];

  assign dec_err = (off[1:0] != 2'b00)
                 | (src.addr < BASE_ADDR)
                 | (|off[31:IW+2]);

  always_comb begin
    go_resp = 1'b0;
    unique case (1'b1)
      (state == S_IDLE): go_resp = MemReq && (WAIT_STATES == 0);
      (state == S_WAIT): go_resp = (cnt == 4'd0);
      default:           go_resp = 1'b0;
    endcase
  end

  assign commit = go_resp & src.we & ~dec_err;

  always_comb begin
    rdata = 32'h0;
    if (!dec_err && !src.we) begin
      rdata = mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[idx] <= src.wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      req_q    <= '0;
      ReadData <= 32'h0;
      MemReady <= 1'b0;
      MemErr   <= 1'b0;
      Busy     <= 1'b0;
    end else begin
      MemReady <= 1'b0;
      MemErr   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (MemReq) begin
            req_q <= src;
            Busy  <= 1'b1;
            if (WAIT_STATES > 0) begin
              state <= S_WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end else begin
              state <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
      if (go_resp) begin
        MemReady <= 1'b1;
        MemErr   <= dec_err;
        ReadData <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder in three
// parameter sets (2 wait states, 0 wait states, relocated base).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst  [3];
  logic        req  [3];
  logic        we   [3];
  logic [31:0] addr [3];
  logic [31:0] wd   [3];
  logic [31:0] rd   [3];
  logic        rdy  [3];
  logic        err  [3];
  logic        busy [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(64), .WAIT_STATES(2), .BASE_ADDR(32'h0)
  ) u_ws2 (
    .clk(clk), .reset(rst[0]), .MemReq(req[0]), .MemWrite(we[0]),
    .Addr(addr[0]), .WriteData(wd[0]), .ReadData(rd[0]),
    .MemReady(rdy[0]), .MemErr(err[0]), .Busy(busy[0])
  );

  dmem_responder #(
    .DEPTH_WORDS(64), .WAIT_STATES(0), .BASE_ADDR(32'h0)
  ) u_ws0 (
    .clk(clk), .reset(rst[1]), .MemReq(req[1]), .MemWrite(we[1]),
    .Addr(addr[1]), .WriteData(wd[1]), .ReadData(rd[1]),
    .MemReady(rdy[1]), .MemErr(err[1]), .Busy(busy[1])
  );

  dmem_responder #(
    .DEPTH_WORDS(64), .WAIT_STATES(2), .BASE_ADDR(32'h1000)
  ) u_base (
    .clk(clk), .reset(rst[2]), .MemReq(req[2]), .MemWrite(we[2]),
    .Addr(addr[2]), .WriteData(wd[2]), .ReadData(rd[2]),
    .MemReady(rdy[2]), .MemErr(err[2]), .Busy(busy[2])
  );

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i] === 1'b1 && busy[i] === 1'b0 && $isunknown(req[i])) begin
        errors++;
        $error("FAIL xreq dut%0d: MemReq=%b while idle, required 0/1", i, req[i]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, required %h", tag, obs, exp);
    end
  endtask

  task automatic idle_neg(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (busy[i] !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic txn(input int i, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input bit mut,
                     output logic [31:0] r, output logic e,
                     output int lat);
    idle_neg(i);
    req[i]  = 1'b1;
    we[i]   = w;
    addr[i] = a;
    wd[i]   = d;
    lat = 99;
    r   = 'x;
    e   = 'x;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (mut && k == 1) begin
        we[i]   = ~w;
        addr[i] = a ^ 32'h40;
        wd[i]   = ~d;
      end
      if (rdy[i] === 1'b1) begin
        lat = k;
        r   = rd[i];
        e   = err[i];
        break;
      end
    end
    req[i] = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    int          lat;

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0;
      addr[i] = 32'h0; wd[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_rdy%0d", i), 32'(rdy[i]), 32'h0);
      chk($sformatf("rst_err%0d", i), 32'(err[i]), 32'h0);
      chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'h0);
      chk($sformatf("rst_rd%0d", i), rd[i], 32'h0);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;

    // store then load, latency WAIT_STATES+1
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, r, e, lat);
    chk("t1_st_lat", 32'(lat), 32'd3);
    chk("t1_st_err", 32'(e), 32'd0);
    chk("t1_st_rd", r, 32'h0);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0, r, e, lat);
    chk("t1_ld_lat", 32'(lat), 32'd3);
    chk("t1_ld_err", 32'(e), 32'd0);
    chk("t1_ld_rd", r, 32'hDEAD_BEEF);

    txn(0, 1'b1, 32'h0, 32'h0101_0101, 1'b0, r, e, lat);
    txn(0, 1'b1, 32'hFC, 32'h3F3F_3F3F, 1'b0, r, e, lat);
    chk("top_st_err", 32'(e), 32'd0);
    txn(0, 1'b0, 32'hFC, 32'h0, 1'b0, r, e, lat);
    chk("top_ld_err", 32'(e), 32'd0);
    chk("top_ld_rd", r, 32'h3F3F_3F3F);

    // error responses
    txn(0, 1'b0, 32'h12, 32'h0, 1'b0, r, e, lat);
    chk("mis_ld_lat", 32'(lat), 32'd3);
    chk("mis_ld_err", 32'(e), 32'd1);
    chk("mis_ld_rd", r, 32'h0);
    txn(0, 1'b0, 32'h100, 32'h0, 1'b0, r, e, lat);
    chk("oor_ld_err", 32'(e), 32'd1);
    chk("oor_ld_rd", r, 32'h0);
    txn(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, r, e, lat);
    chk("wrap_ld_err", 32'(e), 32'd1);
    txn(0, 1'b1, 32'h12, 32'hFFFF_FFFF, 1'b0, r, e, lat);
    chk("mis_st_err", 32'(e), 32'd1);
    txn(0, 1'b1, 32'h100, 32'h0BAD_0BAD, 1'b0, r, e, lat);
    chk("oor_st_err", 32'(e), 32'd1);
    txn(0, 1'b0, 32'h10, 32'h0, 1'b0, r, e, lat);
    chk("keep10_rd", r, 32'hDEAD_BEEF);
    txn(0, 1'b0, 32'h0, 32'h0, 1'b0, r, e, lat);
    chk("keep00_rd", r, 32'h0101_0101);

    // zero wait states, MemReq held high across responses
    txn(1, 1'b1, 32'h0, 32'hA0A0_0001, 1'b0, r, e, lat);
    chk("ws0_st_lat", 32'(lat), 32'd1);
    txn(1, 1'b1, 32'h4, 32'hB0B0_0002, 1'b0, r, e, lat);
    idle_neg(1);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
    @(posedge clk); #1;
    chk("b2b_rdy0", 32'(rdy[1]), 32'd1);
    chk("b2b_busy0", 32'(busy[1]), 32'd1);
    chk("b2b_rd0", rd[1], 32'hA0A0_0001);
    addr[1] = 32'h4;
    @(posedge clk); #1;
    chk("b2b_rdy1", 32'(rdy[1]), 32'd0);
    chk("b2b_busy1", 32'(busy[1]), 32'd0);
    @(posedge clk); #1;
    chk("b2b_rdy2", 32'(rdy[1]), 32'd1);
    chk("b2b_busy2", 32'(busy[1]), 32'd1);
    chk("b2b_rd2", rd[1], 32'hB0B0_0002);
    req[1] = 1'b0;
    @(posedge clk); #1;
    chk("b2b_rdy3", 32'(rdy[1]), 32'd0);
    chk("b2b_busy3", 32'(busy[1]), 32'd0);

    // relocated base address
    txn(2, 1'b1, 32'h0FFC, 32'h77, 1'b0, r, e, lat);
    chk("base_lo_err", 32'(e), 32'd1);
    txn(2, 1'b1, 32'h1000, 32'h55, 1'b0, r, e, lat);
    chk("base_st_err", 32'(e), 32'd0);
    txn(2, 1'b0, 32'h1000, 32'h0, 1'b0, r, e, lat);
    chk("base_ld_err", 32'(e), 32'd0);
    chk("base_ld_rd", r, 32'h55);
    txn(2, 1'b0, 32'h1100, 32'h0, 1'b0, r, e, lat);
    chk("base_hi_err", 32'(e), 32'd1);

    // reset during WAIT aborts a pending store
    txn(0, 1'b1, 32'h8, 32'h1111, 1'b0, r, e, lat);
    txn(0, 1'b0, 32'h8, 32'h0, 1'b0, r, e, lat);
    chk("pre_rst_rd", r, 32'h1111);
    idle_neg(0);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; wd[0] = 32'h1234;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy[0]), 32'd1);
    @(negedge clk);
    rst[0] = 1'b0;
    #1;
    chk("abort_rdy", 32'(rdy[0]), 32'd0);
    chk("abort_err", 32'(err[0]), 32'd0);
    chk("abort_busy0", 32'(busy[0]), 32'd0);
    chk("abort_rd", rd[0], 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_rdy_c%0d", k), 32'(rdy[0]), 32'd0);
    end
    @(negedge clk);
    req[0] = 1'b0;
    rst[0] = 1'b1;
    txn(0, 1'b0, 32'h8, 32'h0, 1'b0, r, e, lat);
    chk("abort_ld_err", 32'(e), 32'd0);
    chk("abort_ld_rd", r, 32'h1111);

    // payload changes after acceptance have no effect
    txn(0, 1'b1, 32'h60, 32'h6060_6060, 1'b0, r, e, lat);
    txn(0, 1'b1, 32'h20, 32'hCAFE_0006, 1'b1, r, e, lat);
    chk("mut_st_lat", 32'(lat), 32'd3);
    chk("mut_st_err", 32'(e), 32'd0);
    chk("mut_st_rd", r, 32'h0);
    txn(0, 1'b0, 32'h20, 32'h0, 1'b1, r, e, lat);
    chk("mut_ld_rd", r, 32'hCAFE_0006);
    txn(0, 1'b0, 32'h60, 32'h0, 1'b0, r, e, lat);
    chk("mut_keep60", r, 32'h6060_6060);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
